// File: rtl/accel_pkg.sv
// accel_pkg: shared accelerator types and default widths.
package accel_pkg;
   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 8;
   typedef enum logic [1:0] {IDLE, LOADED, WRITE, DONE} or_state_t;
endpackage

// File: rtl/output_router.sv
// output_router: captures a group of psum lanes and drains them as sequential memory writes.
module output_router
   import accel_pkg::*;
#(
   parameter int ROUTER_COUNT = 2,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_reg_clear,
   input  logic [ADDR_WIDTH-1:0]              i_addr_start,
   input  logic [ADDR_WIDTH-1:0]              i_route_size,
   input  logic                               i_psum_out_en,
   input  logic [ROUTER_COUNT*DATA_WIDTH-1:0] i_psum,
   input  logic                               i_en,
   output logic [DATA_WIDTH-1:0]              o_data_out,
   output logic [ADDR_WIDTH-1:0]              o_addr_out,
   output logic                               o_write_en,
   output logic                               o_done,
   output logic                               o_busy,
   output logic                               o_overrun
);
   localparam int IW = $clog2(ROUTER_COUNT + 1);
   localparam int SW = (ROUTER_COUNT > 1) ? $clog2(ROUTER_COUNT) : 1;
   or_state_t state, state_n;
   logic [DATA_WIDTH-1:0] buffer [ROUTER_COUNT];
   logic [ADDR_WIDTH-1:0] ptr;
   logic [IW-1:0] idx, n_q, n_eff;
   logic [SW-1:0] sel;
   assign n_eff = (i_route_size > ADDR_WIDTH'(ROUTER_COUNT)) ? IW'(ROUTER_COUNT) : IW'(i_route_size);
   assign sel = idx[SW-1:0];
   assign o_busy = (state == LOADED) || (state == WRITE);
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = i_psum_out_en ? LOADED : IDLE;
         LOADED:  state_n = !i_en ? LOADED : (n_eff == '0) ? DONE : WRITE;
         WRITE:   state_n = (idx == n_q - IW'(1)) ? DONE : WRITE;
         DONE:    state_n = i_en ? DONE : IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst || i_reg_clear) begin
         state <= IDLE;
         ptr <= i_rst ? '0 : i_addr_start;
         idx <= '0;
         n_q <= '0;
         for (int k = 0; k < ROUTER_COUNT; k++) buffer[k] <= '0;
         o_data_out <= '0;
         o_addr_out <= '0;
         o_write_en <= 1'b0;
         o_done <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         state <= state_n;
         o_write_en <= (state == WRITE);
         o_done <= (state == DONE) && i_en;
         if (i_psum_out_en && state != IDLE) o_overrun <= 1'b1;
         if (i_psum_out_en && state == IDLE)
            for (int k = 0; k < ROUTER_COUNT; k++) buffer[k] <= i_psum[k*DATA_WIDTH +: DATA_WIDTH];
         if (state == LOADED && i_en) begin
            idx <= '0;
            n_q <= n_eff;
         end
         // The group size is frozen on entry so i_route_size may change mid-drain.
         if (state == WRITE) begin
            o_data_out <= buffer[sel];
            o_addr_out <= ptr;
            ptr <= ptr + ADDR_WIDTH'(1);
            idx <= idx + IW'(1);
         end
      end
   end
endmodule

// File: tb/tb_output_router.sv
// tb_output_router: randomized self-checking bench for output_router against a group-level model.
module tb_output_router;
   localparam int RC = 2, DW = 16, AW = 8;
   logic i_clk = 1'b0, i_rst = 1'b1, i_reg_clear = 1'b0, i_psum_out_en = 1'b0, i_en = 1'b0;
   logic [AW-1:0] i_addr_start = '0, i_route_size = '0;
   logic [RC*DW-1:0] i_psum = '0;
   logic [DW-1:0] o_data_out;
   logic [AW-1:0] o_addr_out;
   logic o_write_en, o_done, o_busy, o_overrun;
   int checks = 0, failures = 0;
   logic [AW-1:0] mdl_ptr;
   logic [AW-1:0] wa[$];
   logic [DW-1:0] wd[$];
   int wc[$];
   int done_lat;
   bit loaded_ok, done_hold, done_fell, ovr_seen;

   output_router #(.ROUTER_COUNT(RC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_reg_clear(i_reg_clear), .i_addr_start(i_addr_start),
      .i_route_size(i_route_size), .i_psum_out_en(i_psum_out_en), .i_psum(i_psum), .i_en(i_en),
      .o_data_out(o_data_out), .o_addr_out(o_addr_out), .o_write_en(o_write_en),
      .o_done(o_done), .o_busy(o_busy), .o_overrun(o_overrun)
   );

   always #5 i_clk = ~i_clk;

   task automatic clear_to(input logic [AW-1:0] a);
      @(negedge i_clk);
      i_reg_clear = 1'b1;
      i_addr_start = a;
      @(negedge i_clk);
      i_reg_clear = 1'b0;
      mdl_ptr = a;
   endtask

   // Capture a group, hold in LOADED, then drain with i_en high and record every write.
   task automatic run_group(input logic [RC*DW-1:0] psum, input logic [AW-1:0] size, input int pulse_at);
      wa.delete(); wd.delete(); wc.delete();
      done_lat = -1;
      @(negedge i_clk);
      i_psum = psum;
      i_psum_out_en = 1'b1;
      @(negedge i_clk);
      i_psum_out_en = 1'b0;
      i_psum = ~psum;
      repeat (2) @(negedge i_clk);
      loaded_ok = o_busy && !o_write_en && !o_done;
      i_route_size = size;
      i_en = 1'b1;
      for (int c = 1; c <= 20 && done_lat < 0; c++) begin
         @(negedge i_clk);
         if (o_write_en) begin
            wa.push_back(o_addr_out);
            wd.push_back(o_data_out);
            wc.push_back(c);
         end
         if (o_done) done_lat = c;
         i_psum_out_en = (c == pulse_at);
      end
      i_psum_out_en = 1'b0;
      ovr_seen = o_overrun;
      @(negedge i_clk);
      done_hold = o_done;
      i_en = 1'b0;
      @(negedge i_clk);
      done_fell = !o_done;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge i_clk);
      checks++;
      if ({o_write_en, o_done, o_busy, o_overrun, o_data_out, o_addr_out} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got we=%b done=%b busy=%b ovr=%b data=%h addr=%h, want all 0",
                  o_write_en, o_done, o_busy, o_overrun, o_data_out, o_addr_out);
      end
      i_rst = 1'b0;
      mdl_ptr = '0;
      i_en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge i_clk);
         checks++;
         if ({o_write_en, o_done, o_busy} !== 3'b000) begin
            failures++;
            $display("FAIL idle_ignores_en: cycle %0d got we/done/busy=%b, want 000", c, {o_write_en, o_done, o_busy});
         end
      end
      i_en = 1'b0;
   endtask

   task automatic test_basic;
      clear_to(8'h10);
      run_group({16'hBBBB, 16'hAAAA}, 8'd2, -1);
      checks++;
      if (!loaded_ok) begin
         failures++;
         $display("FAIL loaded_hold: got busy=%b we=%b done=%b, want busy only", o_busy, o_write_en, o_done);
      end
      checks++;
      if (wa.size() != 2) begin
         failures++;
         $display("FAIL basic_count: got %0d writes, want 2", wa.size());
      end else begin
         checks++;
         if (wa[0] !== 8'h10 || wd[0] !== 16'hAAAA || wa[1] !== 8'h11 || wd[1] !== 16'hBBBB) begin
            failures++;
            $display("FAIL basic_writes: got (%h,%h)(%h,%h), want (10,aaaa)(11,bbbb)", wa[0], wd[0], wa[1], wd[1]);
         end
         checks++;
         if (wc[0] != 2 || wc[1] != 3) begin
            failures++;
            $display("FAIL basic_timing: got write cycles %0d,%0d, want 2,3", wc[0], wc[1]);
         end
      end
      checks++;
      if (done_lat != 4 || !done_hold || !done_fell) begin
         failures++;
         $display("FAIL basic_done: got lat=%0d hold=%b fell=%b, want lat=4 hold=1 fell=1", done_lat, done_hold, done_fell);
      end
      mdl_ptr = mdl_ptr + 8'd2;
   endtask

   task automatic test_second_group;
      run_group({16'h2222, 16'h1111}, 8'd2, -1);
      checks++;
      if (wa.size() != 2 || wa[0] !== 8'h12 || wd[0] !== 16'h1111 || wa[1] !== 8'h13 || wd[1] !== 16'h2222) begin
         failures++;
         $display("FAIL second_group: got %0d writes first=(%h,%h), want (12,1111)(13,2222)",
                  wa.size(), wa.size() > 0 ? wa[0] : 8'h0, wd.size() > 0 ? wd[0] : 16'h0);
      end
      mdl_ptr = mdl_ptr + 8'd2;
   endtask

   task automatic test_sizes;
      run_group({16'h3333, 16'h4444}, 8'd5, -1);
      checks++;
      if (wa.size() != RC || done_lat != RC + 2) begin
         failures++;
         $display("FAIL oversize: got %0d writes lat=%0d, want %0d writes lat=%0d", wa.size(), done_lat, RC, RC + 2);
      end
      mdl_ptr = mdl_ptr + 8'(RC);
      run_group({16'h5555, 16'h6666}, 8'd0, -1);
      checks++;
      if (wa.size() != 0 || done_lat != 2) begin
         failures++;
         $display("FAIL zero_size: got %0d writes lat=%0d, want 0 writes lat=2", wa.size(), done_lat);
      end
      run_group({16'h7777, 16'h8888}, 8'd1, -1);
      checks++;
      if (wa.size() != 1 || wa[0] !== mdl_ptr || wd[0] !== 16'h8888) begin
         failures++;
         $display("FAIL single_after_zero: got %0d writes first=(%h,%h), want (%h,8888)",
                  wa.size(), wa.size() > 0 ? wa[0] : 8'h0, wd.size() > 0 ? wd[0] : 16'h0, mdl_ptr);
      end
      mdl_ptr = mdl_ptr + 8'd1;
   endtask

   task automatic test_wrap;
      clear_to(8'hFF);
      run_group({16'hCAFE, 16'hBEEF}, 8'd2, -1);
      checks++;
      if (wa.size() != 2 || wa[0] !== 8'hFF || wa[1] !== 8'h00 || wd[1] !== 16'hCAFE) begin
         failures++;
         $display("FAIL wrap: got %0d writes addrs=%h,%h, want ff,00", wa.size(),
                  wa.size() > 0 ? wa[0] : 8'h0, wa.size() > 1 ? wa[1] : 8'h0);
      end
      mdl_ptr = 8'h01;
   endtask

   task automatic test_overrun;
      clear_to(8'h40);
      checks++;
      if (o_overrun !== 1'b0) begin
         failures++;
         $display("FAIL overrun_clear: got %b, want 0", o_overrun);
      end
      run_group({16'h0DD0, 16'h0EE0}, 8'd2, 1);
      checks++;
      if (!ovr_seen || wa.size() != 2 || wd[0] !== 16'h0EE0 || wd[1] !== 16'h0DD0) begin
         failures++;
         $display("FAIL overrun_mid_write: got ovr=%b writes=%0d data=%h,%h, want ovr=1 0ee0,0dd0", ovr_seen,
                  wa.size(), wd.size() > 0 ? wd[0] : 16'h0, wd.size() > 1 ? wd[1] : 16'h0);
      end
      checks++;
      if (o_overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_sticky: got %b, want 1", o_overrun);
      end
      mdl_ptr = mdl_ptr + 8'd2;
   endtask

   task automatic test_abort;
      int c;
      clear_to(8'h20);
      @(negedge i_clk);
      i_psum = {16'h9999, 16'h1234};
      i_psum_out_en = 1'b1;
      @(negedge i_clk);
      i_psum_out_en = 1'b0;
      i_route_size = 8'd2;
      i_en = 1'b1;
      c = 0;
      while (!o_write_en && c < 6) begin
         @(negedge i_clk);
         c++;
      end
      checks++;
      if (!o_write_en || o_addr_out !== 8'h20) begin
         failures++;
         $display("FAIL abort_first_write: got we=%b addr=%h after %0d cycles, want we=1 addr=20", o_write_en, o_addr_out, c);
      end
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      checks++;
      if ({o_write_en, o_done, o_busy, o_overrun, o_data_out, o_addr_out} !== '0) begin
         failures++;
         $display("FAIL abort_reset: got we=%b done=%b busy=%b ovr=%b data=%h addr=%h, want all 0",
                  o_write_en, o_done, o_busy, o_overrun, o_data_out, o_addr_out);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         checks++;
         if (o_write_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_more_writes: cycle %0d got we=%b, want 0", k, o_write_en);
         end
      end
      i_en = 1'b0;
      mdl_ptr = '0;
   endtask

   task automatic test_random;
      logic [RC*DW-1:0] p;
      logic [AW-1:0] sz;
      int n;
      clear_to(8'($urandom));
      for (int g = 0; g < 15; g++) begin
         p = $urandom();
         sz = 8'($urandom_range(0, 4));
         n = (sz > RC) ? RC : int'(sz);
         run_group(p, sz, -1);
         checks++;
         if (wa.size() != n || done_lat != (n == 0 ? 2 : n + 2)) begin
            failures++;
            $display("FAIL rand_group%0d: got %0d writes lat=%0d, want %0d writes lat=%0d",
                     g, wa.size(), done_lat, n, n == 0 ? 2 : n + 2);
         end else begin
            for (int k = 0; k < n; k++) begin
               checks++;
               if (wa[k] !== mdl_ptr + 8'(k) || wd[k] !== p[k*DW +: DW] || wc[k] != k + 2) begin
                  failures++;
                  $display("FAIL rand_write%0d_%0d: got (%h,%h)@%0d, want (%h,%h)@%0d", g, k, wa[k], wd[k], wc[k],
                           mdl_ptr + 8'(k), p[k*DW +: DW], k + 2);
               end
            end
         end
         mdl_ptr = mdl_ptr + 8'(n);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_second_group();
      test_sizes();
      test_wrap();
      test_overrun();
      test_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
